// File: rtl/ccd_line_capture.sv
// ----------------------------------------------------------------------------
// ccd_line_capture
//
// Receive-side framing for a linear CCD read out under shift-gate (SH)
// control. The block watches the SH pulse train that goes to the sensor and
// uses it to cut the ADC sample stream into lines:
//   - a qualified SH pulse (high for at least SH_MIN_HIGH cycles) starts a
//     readout; the SH fall arms the framer;
//   - the first DUMMY_LEAD valid samples after the fall are discarded;
//   - the next PIXELS valid samples are forwarded with their index and with
//     line start / line end markers;
//   - an SH rise before the line completes aborts it (overrun pulse);
//   - SH_TIMEOUT cycles after a rise with no further rise raise a sticky
//     timeout flag and drop any partial line.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous reset, active-high
//   sh_in       in   SH pulse, already synchronous to clk
//   adc_data    in   ADC sample (DATA_W bits)
//   adc_valid   in   adc_data is valid this cycle
//   pix_data    out  forwarded sample (DATA_W bits)
//   pix_valid   out  pix_data / pix_index are valid
//   pix_index   out  0..PIXELS-1 position of the forwarded sample
//   line_start  out  marks the sample with index 0
//   line_end    out  marks the sample with index PIXELS-1
//   line_count  out  number of completed lines, wraps 0xFFFF -> 0
//   overrun     out  one-cycle pulse: line aborted by an early SH rise
//   timeout     out  sticky: no SH rise within SH_TIMEOUT cycles
//
// All outputs are registered; a forwarded sample appears one cycle after the
// cycle in which it was presented with adc_valid.
// ----------------------------------------------------------------------------
module ccd_line_capture #(
    parameter int DATA_W      = 12,
    parameter int PIXELS      = 3648,
    parameter int DUMMY_LEAD  = 32,
    parameter int SH_MIN_HIGH = 2,
    parameter int SH_TIMEOUT  = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sh_in,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic [15:0]       pix_index,
    output logic              line_start,
    output logic              line_end,
    output logic [15:0]       line_count,
    output logic              overrun,
    output logic              timeout
);

    // ------------------------------------------------------------------------
    // Constants folded to the 16-bit counter width
    // ------------------------------------------------------------------------
    localparam logic [15:0] C_LAST_PIX = 16'(PIXELS - 1);
    localparam logic [15:0] C_DUMMY    = 16'(DUMMY_LEAD);
    localparam logic [15:0] C_MIN_HIGH = 16'(SH_MIN_HIGH);
    localparam logic [15:0] C_TIMEOUT  = 16'(SH_TIMEOUT);
    localparam logic [15:0] C_CNT_MAX  = 16'hFFFF;

    typedef enum logic [2:0] {
        S_WAIT_SH  = 3'd0,
        S_SH_HIGH  = 3'd1,
        S_SKIP     = 3'd2,
        S_CAPTURE  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------------
    state_t      r_state;
    logic        r_sh_q;
    logic [15:0] r_hcnt;      // SH high width of the current pulse
    logic [15:0] r_scnt;      // dummy samples discarded so far
    logic [15:0] r_pcnt;      // index of the next sample to forward
    logic [15:0] r_tcnt;      // cycles since the last SH rise
    logic        r_tarmed;    // a rise has been seen since reset

    // Registered outputs
    logic [DATA_W-1:0] r_pix_data;
    logic              r_pix_valid;
    logic [15:0]       r_pix_index;
    logic              r_line_start;
    logic              r_line_end;
    logic [15:0]       r_line_count;
    logic              r_overrun;
    logic              r_timeout;

    // Next-state / decode wires
    state_t      w_state_next;
    logic [15:0] w_hcnt_next;
    logic [15:0] w_scnt_next;
    logic [15:0] w_pcnt_next;
    logic        w_rise;
    logic        w_fall;
    logic        w_tout_hit;
    logic        w_fwd;
    logic        w_last;
    logic        w_overrun;

    // ------------------------------------------------------------------------
    // SH edge detection. r_sh_q resets high so that an SH line already high
    // when reset is released is not mistaken for a fresh rise.
    // ------------------------------------------------------------------------
    assign w_rise = sh_in & ~r_sh_q;
    assign w_fall = ~sh_in & r_sh_q;

    // The timeout only counts once a first rise has been seen, so an idle
    // sensor after reset does not flag. A rise in the very cycle the count
    // expires wins: it restarts the count and is treated as a normal rise.
    assign w_tout_hit = r_tarmed && (r_tcnt == C_TIMEOUT) && !w_rise;

    // ------------------------------------------------------------------------
    // Process 1: state register and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_WAIT_SH;
            r_sh_q       <= 1'b1;
            r_hcnt       <= '0;
            r_scnt       <= '0;
            r_pcnt       <= '0;
            r_tcnt       <= '0;
            r_tarmed     <= 1'b0;
            r_pix_data   <= '0;
            r_pix_valid  <= 1'b0;
            r_pix_index  <= '0;
            r_line_start <= 1'b0;
            r_line_end   <= 1'b0;
            r_line_count <= '0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sh_q  <= sh_in;
            r_hcnt  <= w_hcnt_next;
            r_scnt  <= w_scnt_next;
            r_pcnt  <= w_pcnt_next;

            // Rise-to-rise watchdog, saturating at the timeout value so the
            // flag condition holds until the next rise.
            if (w_rise) begin
                r_tcnt   <= '0;
                r_tarmed <= 1'b1;
            end else if (r_tarmed && (r_tcnt != C_TIMEOUT)) begin
                r_tcnt <= r_tcnt + 16'd1;
            end

            if (w_rise) begin
                r_timeout <= 1'b0;
            end else if (w_tout_hit) begin
                r_timeout <= 1'b1;
            end

            // Pixel output stage. Data and index only move on a forwarded
            // sample; the strobes are refreshed every cycle.
            r_pix_valid  <= w_fwd;
            r_line_start <= w_fwd && (r_pcnt == 16'd0);
            r_line_end   <= w_last;
            r_overrun    <= w_overrun;
            if (w_fwd) begin
                r_pix_data  <= adc_data;
                r_pix_index <= r_pcnt;
            end
            if (w_last) begin
                r_line_count <= r_line_count + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Process 2: next-state and counter logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_hcnt_next  = r_hcnt;
        w_scnt_next  = r_scnt;
        w_pcnt_next  = r_pcnt;

        if (w_tout_hit) begin
            // Watchdog expiry drops whatever line was in flight.
            w_state_next = S_WAIT_SH;
        end else begin
            case (r_state)
                S_WAIT_SH: begin
                    if (w_rise) begin
                        w_state_next = S_SH_HIGH;
                        w_hcnt_next  = 16'd1;
                    end
                end

                S_SH_HIGH: begin
                    if (w_fall) begin
                        w_scnt_next = '0;
                        w_pcnt_next = '0;
                        if (r_hcnt < C_MIN_HIGH) begin
                            // Too short to be a real transfer pulse.
                            w_state_next = S_WAIT_SH;
                        end else if (C_DUMMY == 16'd0) begin
                            w_state_next = S_CAPTURE;
                        end else begin
                            w_state_next = S_SKIP;
                        end
                    end else if (sh_in && (r_hcnt != C_CNT_MAX)) begin
                        w_hcnt_next = r_hcnt + 16'd1;
                    end
                end

                S_SKIP: begin
                    if (w_rise) begin
                        // Early SH: abort and start measuring the new pulse.
                        w_state_next = S_SH_HIGH;
                        w_hcnt_next  = 16'd1;
                    end else if (adc_valid) begin
                        w_scnt_next = r_scnt + 16'd1;
                        if ((r_scnt + 16'd1) == C_DUMMY) begin
                            w_state_next = S_CAPTURE;
                            w_pcnt_next  = '0;
                        end
                    end
                end

                S_CAPTURE: begin
                    if (adc_valid && (r_pcnt == C_LAST_PIX)) begin
                        // The last sample completes the line even if SH rises
                        // in the same cycle; that rise then starts the next
                        // pulse directly.
                        w_pcnt_next = '0;
                        if (w_rise) begin
                            w_state_next = S_SH_HIGH;
                            w_hcnt_next  = 16'd1;
                        end else begin
                            w_state_next = S_DONE;
                        end
                    end else if (w_rise) begin
                        w_state_next = S_SH_HIGH;
                        w_hcnt_next  = 16'd1;
                    end else if (adc_valid) begin
                        w_pcnt_next = r_pcnt + 16'd1;
                    end
                end

                S_DONE: begin
                    if (w_rise) begin
                        w_state_next = S_SH_HIGH;
                        w_hcnt_next  = 16'd1;
                    end
                end

                default: begin
                    w_state_next = S_WAIT_SH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Process 3: output decode feeding the registered output stage
    // ------------------------------------------------------------------------
    always_comb begin
        w_fwd     = 1'b0;
        w_last    = 1'b0;
        w_overrun = 1'b0;

        if (!w_tout_hit) begin
            if (r_state == S_CAPTURE) begin
                // A sample that coincides with an aborting rise is dropped,
                // except the final one, which still closes the line.
                if (adc_valid && (!w_rise || (r_pcnt == C_LAST_PIX))) begin
                    w_fwd  = 1'b1;
                    w_last = (r_pcnt == C_LAST_PIX);
                end
                if (w_rise && !(adc_valid && (r_pcnt == C_LAST_PIX))) begin
                    w_overrun = 1'b1;
                end
            end else if (r_state == S_SKIP) begin
                w_overrun = w_rise;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------------
    assign pix_data   = r_pix_data;
    assign pix_valid  = r_pix_valid;
    assign pix_index  = r_pix_index;
    assign line_start = r_line_start;
    assign line_end   = r_line_end;
    assign line_count = r_line_count;
    assign overrun    = r_overrun;
    assign timeout    = r_timeout;

endmodule

// File: tb/tb_ccd_line_capture.sv
// ----------------------------------------------------------------------------
// Bench for ccd_line_capture with PIXELS=8, DUMMY_LEAD=2, SH_MIN_HIGH=2,
// SH_TIMEOUT=100. Sample values driven are 0,1,2,... per readout, so the
// k-th forwarded pixel of a line is expected to carry k+2.
// ----------------------------------------------------------------------------
module tb_ccd_line_capture;

    localparam int DW = 12;
    localparam int NPIX = 8;

    logic          clk;
    logic          rst;
    logic          sh_in;
    logic [DW-1:0] adc_data;
    logic          adc_valid;
    logic [DW-1:0] pix_data;
    logic          pix_valid;
    logic [15:0]   pix_index;
    logic          line_start;
    logic          line_end;
    logic [15:0]   line_count;
    logic          overrun;
    logic          timeout;

    ccd_line_capture #(
        .DATA_W      (DW),
        .PIXELS      (NPIX),
        .DUMMY_LEAD  (2),
        .SH_MIN_HIGH (2),
        .SH_TIMEOUT  (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sh_in      (sh_in),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_index  (pix_index),
        .line_start (line_start),
        .line_end   (line_end),
        .line_count (line_count),
        .overrun    (overrun),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Output monitor: collects forwarded pixels and checks one-cycle latency
    // against what the bench drove on the previous edge.
    // ------------------------------------------------------------------------
    typedef struct {
        logic [DW-1:0] data;
        logic [15:0]   idx;
        logic          st;
        logic          en;
    } pix_t;

    pix_t          pix_q[$];
    int            ovr_cnt = 0;
    int            end_cnt = 0;
    logic          prev_valid = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    always @(posedge clk) begin
        prev_valid <= adc_valid;
        prev_data  <= adc_data;
    end

    always @(negedge clk) begin
        if (overrun === 1'b1) ovr_cnt++;
        if (pix_valid === 1'b1) begin
            pix_q.push_back(pix_t'{pix_data, pix_index, line_start, line_end});
            if (line_end === 1'b1) end_cnt++;
            chk("latency_valid", {31'd0, prev_valid}, 32'd1);
            chk("latency_data", {20'd0, pix_data}, {20'd0, prev_data});
        end else begin
            chk("strobes_idle", {30'd0, line_start, line_end}, 32'd0);
        end
    end

    // Compare npix queued pixels starting at base with a fresh line 0..npix-1.
    task automatic check_pixels(input string tag, input int base, input int npix);
        for (int k = 0; k < npix; k++) begin
            if (base + k < pix_q.size()) begin
                chk({tag, "_data"}, {20'd0, pix_q[base+k].data}, k + 2);
                chk({tag, "_index"}, {16'd0, pix_q[base+k].idx}, k);
                chk({tag, "_flags"}, {30'd0, pix_q[base+k].st, pix_q[base+k].en},
                    {30'd0, (k == 0), (k == NPIX - 1)});
            end
        end
    endtask

    // One SH pulse of `hi` cycles, then nsamp samples with `gap` idle cycles
    // between them, then a short drain.
    task automatic run_line(input int hi, input int gap, input int nsamp);
        sh_in = 1'b0; adc_valid = 1'b0;
        tick(); tick();
        sh_in = 1'b1;
        repeat (hi) tick();
        sh_in = 1'b0;
        tick();
        for (int i = 0; i < nsamp; i++) begin
            adc_valid = 1'b1;
            adc_data  = DW'(i);
            tick();
            adc_valid = 1'b0;
            repeat (gap) tick();
        end
        adc_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic check_all_zero(input string tag);
        @(negedge clk);
        chk({tag, "_pix_valid"}, {31'd0, pix_valid}, 32'd0);
        chk({tag, "_pix_data"}, {20'd0, pix_data}, 32'd0);
        chk({tag, "_pix_index"}, {16'd0, pix_index}, 32'd0);
        chk({tag, "_line_start"}, {31'd0, line_start}, 32'd0);
        chk({tag, "_line_end"}, {31'd0, line_end}, 32'd0);
        chk({tag, "_line_count"}, {16'd0, line_count}, 32'd0);
        chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
        chk({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    endtask

    typedef struct {
        string name;
        int    hi;
        int    gap;
        int    nsamp;
        int    exp_pix;
        int    exp_inc;
    } vec_t;

    vec_t tbl[5];
    int   exp_lines;

    initial begin
        tbl[0] = '{"nominal",   25, 0, 10, 8, 1};
        tbl[1] = '{"gaps",       3, 1, 10, 8, 1};
        tbl[2] = '{"glitch",     1, 0, 10, 0, 0};
        tbl[3] = '{"min_high",   2, 0, 12, 8, 1};
        tbl[4] = '{"wide_gaps",  2, 2, 10, 8, 1};

        rst = 1'b1; sh_in = 1'b1; adc_valid = 1'b0; adc_data = '0;
        exp_lines = 0;
        repeat (3) tick();
        check_all_zero("reset");

        // SH already high at reset release must not count as a rise.
        rst = 1'b0;
        pix_q.delete();
        adc_valid = 1'b1;
        repeat (6) tick();
        adc_valid = 1'b0;
        tick();
        chk("no_rise_after_reset", pix_q.size(), 0);
        $display("txn reset_release pixels=%0d", pix_q.size());

        // ---------------- table-driven line scenarios ----------------
        for (int v = 0; v < 5; v++) begin
            pix_q.delete(); ovr_cnt = 0; end_cnt = 0;
            run_line(tbl[v].hi, tbl[v].gap, tbl[v].nsamp);
            exp_lines += tbl[v].exp_inc;
            chk({tbl[v].name, "_npix"}, pix_q.size(), tbl[v].exp_pix);
            check_pixels(tbl[v].name, 0, tbl[v].exp_pix);
            chk({tbl[v].name, "_line_count"}, {16'd0, line_count}, exp_lines);
            chk({tbl[v].name, "_line_ends"}, end_cnt, tbl[v].exp_inc);
            chk({tbl[v].name, "_overrun"}, ovr_cnt, 0);
            $display("txn %s pixels=%0d line_count=%0d", tbl[v].name, pix_q.size(), line_count);
        end

        // ---------------- overrun: rise after 5 forwarded pixels ----------------
        pix_q.delete(); ovr_cnt = 0; end_cnt = 0;
        sh_in = 1'b0; tick(); tick();
        sh_in = 1'b1; repeat (3) tick();
        sh_in = 1'b0; tick();
        for (int i = 0; i < 7; i++) begin
            adc_valid = 1'b1; adc_data = DW'(i); tick();
        end
        adc_valid = 1'b0;
        sh_in = 1'b1;
        tick();
        @(negedge clk);
        chk("overrun_pulse", {31'd0, overrun}, 32'd1);
        tick();
        @(negedge clk);
        chk("overrun_one_cycle", {31'd0, overrun}, 32'd0);
        sh_in = 1'b0; tick();
        for (int i = 0; i < 10; i++) begin
            adc_valid = 1'b1; adc_data = DW'(i); tick();
        end
        adc_valid = 1'b0;
        repeat (3) tick();
        exp_lines += 1;
        chk("overrun_npix", pix_q.size(), 13);
        check_pixels("overrun_partial", 0, 5);
        check_pixels("overrun_next", 5, 8);
        chk("overrun_line_ends", end_cnt, 1);
        chk("overrun_count", ovr_cnt, 1);
        chk("overrun_line_count", {16'd0, line_count}, exp_lines);
        $display("txn overrun pixels=%0d overruns=%0d line_count=%0d", pix_q.size(), ovr_cnt, line_count);

        // ---------------- timeout ----------------
        pix_q.delete();
        run_line(3, 0, 10);   // rise edge + 16 further edges
        exp_lines += 1;
        chk("timeout_line_npix", pix_q.size(), 8);
        repeat (70) tick();   // 86 edges after the rise
        @(negedge clk);
        chk("timeout_early", {31'd0, timeout}, 32'd0);
        repeat (25) tick();   // 111 edges after the rise
        @(negedge clk);
        chk("timeout_set", {31'd0, timeout}, 32'd1);
        sh_in = 1'b1; tick();
        @(negedge clk);
        chk("timeout_cleared", {31'd0, timeout}, 32'd0);
        pix_q.delete(); end_cnt = 0;
        run_line(3, 0, 10);
        exp_lines += 1;
        chk("timeout_after_npix", pix_q.size(), 8);
        check_pixels("timeout_after", 0, 8);
        chk("timeout_after_line_count", {16'd0, line_count}, exp_lines);
        $display("txn timeout pixels=%0d line_count=%0d", pix_q.size(), line_count);

        // ---------------- reset mid-capture at index 4 ----------------
        pix_q.delete(); end_cnt = 0; ovr_cnt = 0;
        sh_in = 1'b0; tick(); tick();
        sh_in = 1'b1; repeat (3) tick();
        sh_in = 1'b0; tick();
        for (int i = 0; i < 7; i++) begin
            adc_valid = 1'b1; adc_data = DW'(i); tick();
        end
        rst = 1'b1; adc_valid = 1'b1; adc_data = DW'(7);
        tick();
        check_all_zero("midreset");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            adc_valid = 1'b1; adc_data = DW'(i); tick();
        end
        adc_valid = 1'b0;
        tick();
        chk("midreset_npix", pix_q.size(), 5);
        chk("midreset_no_end", end_cnt, 0);
        chk("midreset_no_overrun", ovr_cnt, 0);
        pix_q.delete();
        run_line(3, 0, 10);
        chk("midreset_after_npix", pix_q.size(), 8);
        check_pixels("midreset_after", 0, 8);
        chk("midreset_line_count", {16'd0, line_count}, 1);
        $display("txn midreset pixels=%0d line_count=%0d", pix_q.size(), line_count);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
